// File: rtl/ofm_pack.sv
// ofm_pack: serializes per-column PE results into requantized int8 bytes
// and packs them into valid/ready output words with a byte-keep mask.
module ofm_pack #(
  parameter int COL       = 8,
  parameter int OFM_WIDTH = 32,
  parameter int OUT_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [COL-1:0]           sum_valid,
  input  logic [COL*OFM_WIDTH-1:0] sum,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     ofm_valid,
  input  logic                     ofm_ready,
  output logic [OUT_BYTES*8-1:0]   ofm_data,
  output logic [OUT_BYTES-1:0]     ofm_keep,
  output logic                     busy,
  output logic                     err_overflow
);

  localparam int OW = OUT_BYTES * 8;
  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam int IW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = OFM_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUT_BYTES);
  localparam logic signed [RW-1:0] QMAX = 127;
  localparam logic signed [RW-1:0] QMIN = -128;

  logic [COL-1:0]           cap_mask;
  logic [COL*OFM_WIDTH-1:0] cap_data;
  logic [OW-1:0]            pack_data;
  logic [CW-1:0]            pack_cnt;
  logic                     flush_pend;

  logic [IW-1:0]            idx;
  logic [OFM_WIDTH-1:0]     sel_sum;
  logic signed [RW-1:0]     ext;
  logic signed [RW-1:0]     rnd;
  logic signed [RW-1:0]     r;
  logic [7:0]               q_byte;

  always_comb begin
    idx = '0;
    for (int i = COL - 1; i >= 0; i--)
      if (cap_mask[i]) idx = IW'(i);
    sel_sum = cap_data[idx*OFM_WIDTH +: OFM_WIDTH];
    ext = {sel_sum[OFM_WIDTH-1], sel_sum};
    rnd = '0;
    if (shift != 5'd0) rnd = RW'(1) << (shift - 5'd1);
    r = (ext + rnd) >>> shift;
    if (relu_en && r[RW-1]) r = '0;
    if (r > QMAX)      q_byte = 8'h7F;
    else if (r < QMIN) q_byte = 8'h80;
    else               q_byte = r[7:0];
  end

  logic            can_out;
  logic            full;
  logic            ser;
  logic            capture;
  logic            ovf;
  logic            load_out;
  logic [OW-1:0]   ld_data;
  logic [OUT_BYTES-1:0] ld_keep;
  logic [CW-1:0]   b_cnt;
  logic [OW-1:0]   b_data;
  logic [CW-1:0]   n_cnt;
  logic [OW-1:0]   n_data;
  logic [COL-1:0]  n_mask;
  logic            n_pend;

  always_comb begin
    can_out  = !ofm_valid || ofm_ready;
    full     = pack_cnt == FULL_CNT;
    ser      = (|cap_mask) && !(full && !can_out);
    capture  = (|sum_valid) && (cap_mask == '0);
    ovf      = (|sum_valid) && (|cap_mask);
    load_out = 1'b0;
    ld_data  = '0;
    ld_keep  = '0;
    b_cnt    = pack_cnt;
    b_data   = pack_data;
    n_mask   = cap_mask;
    n_pend   = flush_pend;

    if (full && can_out) begin
      load_out = 1'b1;
      ld_data  = pack_data;
      ld_keep  = '1;
      b_cnt    = '0;
      b_data   = '0;
    end

    n_cnt  = b_cnt;
    n_data = b_data;
    if (ser) begin
      for (int k = 0; k < OUT_BYTES; k++)
        if (CW'(k) == b_cnt) n_data[k*8 +: 8] = q_byte;
      n_cnt  = b_cnt + CW'(1);
      n_mask = cap_mask & (cap_mask - COL'(1));
    end

    // A word completed by this cycle's byte leaves straight away if it can
    if (!load_out && can_out && n_cnt == FULL_CNT) begin
      load_out = 1'b1;
      ld_data  = n_data;
      ld_keep  = '1;
      n_cnt    = '0;
      n_data   = '0;
    end

    if (flush_pend && cap_mask == '0) begin
      if (pack_cnt == '0) begin
        n_pend = 1'b0;
      end else if (!full && can_out) begin
        load_out = 1'b1;
        ld_data  = pack_data;
        for (int k = 0; k < OUT_BYTES; k++)
          ld_keep[k] = CW'(k) < pack_cnt;
        n_cnt    = '0;
        n_data   = '0;
        n_pend   = 1'b0;
      end
    end

    if (flush)   n_pend = 1'b1;
    if (capture) n_mask = sum_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_mask     <= '0;
      cap_data     <= '0;
      pack_data    <= '0;
      pack_cnt     <= '0;
      flush_pend   <= 1'b0;
      ofm_valid    <= 1'b0;
      ofm_data     <= '0;
      ofm_keep     <= '0;
      err_overflow <= 1'b0;
    end else begin
      cap_mask   <= n_mask;
      pack_data  <= n_data;
      pack_cnt   <= n_cnt;
      flush_pend <= n_pend;
      if (capture) cap_data <= sum;
      if (load_out) begin
        ofm_valid <= 1'b1;
        ofm_data  <= ld_data;
        ofm_keep  <= ld_keep;
      end else if (ofm_ready) begin
        ofm_valid <= 1'b0;
      end
      if (ovf)          err_overflow <= 1'b1;
      else if (err_clr) err_overflow <= 1'b0;
    end
  end

  assign busy = (|cap_mask) || flush_pend;

endmodule

// File: doc/ofm_pack.md
OFM_PACK -- requirements
Module: ofm_pack

Interface
REQ-001 Parameter COL, default 8: number of PE columns, each delivering one result.
REQ-002 Parameter OFM_WIDTH, default 32: signed width of each column result.
REQ-003 Parameter OUT_BYTES, default 8: bytes per output word; output width is OUT_BYTES*8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous and active-low.
REQ-006 sum_valid  input  COL  per-column result valid, one-cycle pulse, no backpressure.
REQ-007 sum  input  COL x OFM_WIDTH  per-column signed accumulated results.
REQ-008 shift  input  5  requantization right-shift amount, 0..31, quasi-static.
REQ-009 relu_en  input  1  clamp negative results to 0 when high, quasi-static.
REQ-010 flush  input  1  one-cycle pulse requesting emission of a partial word.
REQ-011 err_clr  input  1  clears err_overflow.
REQ-012 ofm_valid  output  1  output word valid.
REQ-013 ofm_ready  input  1  downstream accepts the word when high with ofm_valid.
REQ-014 ofm_data  output  OUT_BYTES*8  packed int8 results; first byte in bits [7:0].
REQ-015 ofm_keep  output  OUT_BYTES  byte-valid mask for ofm_data.
REQ-016 busy  output  1  high while the capture mask is non-zero or a flush is pending.
REQ-017 err_overflow  output  1  sticky flag: a result group was dropped.

Function
REQ-018 Capture: when sum_valid != 0 and the capture mask is zero, the block SHALL latch all sum values and sum_valid into the capture registers on that edge.
REQ-019 Overflow: when sum_valid != 0 and the capture mask is non-zero, the block SHALL drop the new group, keep the existing capture, and set err_overflow on that edge.
REQ-020 Serialize: each unstalled cycle, the block SHALL process the lowest-index set bit of the capture mask, clear that bit, and append one byte to the pack register, giving one byte per cycle starting the cycle after capture.
REQ-021 Quantize: the block SHALL compute r = (sum + (shift>0 ? 2^(shift-1) : 0)) >>> shift at OFM_WIDTH+1 bits, apply relu_en (r<0 -> 0), then saturate r to [-128,127].
REQ-022 Pack: the pack register SHALL hold a byte count of 0..OUT_BYTES; the byte at count k SHALL go to bits [8k+7:8k].
REQ-023 Word hand-off: when the count reaches OUT_BYTES, the pack register SHALL transfer to the output register with ofm_keep all-ones if the output register is empty or is being accepted (ofm_valid & ofm_ready) that cycle; otherwise it SHALL stall.
REQ-024 Stall: while the full pack register cannot transfer, serialization SHALL halt, and the capture mask and captured data SHALL hold.
REQ-025 Output hold: ofm_valid, ofm_data and ofm_keep SHALL stay stable until ofm_ready is sampled high.
REQ-026 Flush: a flush pulse SHALL set a pending flag.
REQ-027 Flush execution: when the pending flag is set and the capture mask is zero, a non-zero pack count SHALL transfer under REQ-023 rules with ofm_keep = (1<<count)-1, zeros in unused bytes, and count reset to 0.
REQ-028 Flush completion: the pending flag SHALL clear when the flush executes, or immediately if the count is 0, in which case no word is emitted.
REQ-029 Flush with capture: a flush in the same cycle as a capture SHALL apply after that group is drained.
REQ-030 Word ordering: words SHALL leave in byte-arrival order; no reordering and no byte loss except under REQ-019.
REQ-031 err_clr: err_clr SHALL clear err_overflow; if err_clr and an overflow occur in the same cycle, set SHALL win.

Reset
REQ-032 While rstn is low, ofm_valid, ofm_data, ofm_keep, busy, err_overflow, the capture mask, the pack count and the flush pending flag SHALL be 0.
REQ-033 Reset mid-operation SHALL discard captured, partial and pending output data with no word emitted.

Verification
REQ-034 Full group: shift=0, relu_en=0, sum_valid=8'hFF, sum[i]=i; ofm_ready=1 -> one word 64'h0706050403020100, keep 8'hFF, ofm_valid asserted 8 cycles after capture for 1 cycle.
REQ-035 Stride mask and rounding: sum_valid=8'h55 twice, sum[i]=-300, shift=2 -> each byte -75 (8'hB5); one full word after the second group; repeat with relu_en=1 -> all bytes 8'h00.
REQ-036 Saturation: sum=100000 -> 8'h7F; sum=-100000 -> 8'h80; shift=31 on -1 -> 8'h00.
REQ-037 Backpressure: ofm_ready=0 for 20 cycles across two full groups -> first word held stable, serializer stalls with busy=1, both words delivered intact in order after ofm_ready=1.
REQ-038 Flush and overflow: 3 bytes captured, then flush -> keep 8'h07, upper 5 bytes zero; sum_valid re-pulsed while busy -> err_overflow=1, group dropped, cleared by err_clr.
